chan_req_ctrl: RTL and testbench
================================

// Module: chan_req_ctrl
// PURPOSE
//  Per-input-port requester side of the channel arbitration handshake. Buffers
//  upstream packets store-and-forward, requests the shared channel from the
//  arbiter, holds the request until granted (resp) or refused (nresp), backs off
//  on refusal, then streams the granted packet one word/cycle and flags the end.
//  One instance per port; its o_chann_req/o_end feed bit i of the arbiter.
// PARAMETERS
//  DW       16  packet word width
//  DEPTH    64  buffer depth in words, power of 2, >=4; max packet length = DEPTH
//  BACKOFF  4   cycles o_chann_req stays low after an nresp, >=1
// PORTS
//  i_clk        in   1      clock
//  i_rst_n      in   1      async active-low reset
//  i_pkt_vld    in   1      upstream word valid
//  i_pkt_data   in   DW     upstream word
//  i_pkt_eop    in   1      upstream last word of packet
//  o_pkt_rdy    out  1      buffer can accept; write = i_pkt_vld & o_pkt_rdy
//  o_chann_req  out  1      channel request to arbiter
//  i_chan_resp  in   1      1-cycle grant pulse from arbiter
//  i_chan_nresp in   1      1-cycle refusal pulse from arbiter
//  o_data       out  DW     channel data word
//  o_data_vld   out  1      o_data valid
//  o_end        out  1      last word of granted packet (to arbiter i_end)
//  o_err        out  1      sticky: buffer full with no complete packet
// BEHAVIOUR
//  Reset (async, immediate): FSM=IDLE, buffer empty, pkt_cnt=0, backoff cnt=0;
//   o_chann_req/o_data_vld/o_end/o_err=0, o_data=0, o_pkt_rdy=1. Reset mid-
//   transfer discards all buffered data; no o_end is produced.
//  Buffer: FIFO of DEPTH words + eop bit, $clog2(DEPTH)+1-bit pointers, wrap
//   naturally. o_pkt_rdy = ~full (combinational). pkt_cnt (clog2(DEPTH)+1 bits)
//   +1 on write with eop, -1 on read of eop word, unchanged if both same cycle.
//  Arbiter contract: arbiter samples req while ready; resp or nresp arrives the
//   cycle after; req seen while arbiter busy gets no response -> req is held.
//  FSM (all outputs registered):
//   IDLE : pkt_cnt!=0 -> REQ (o_chann_req=1 from next cycle).
//   REQ  : o_chann_req=1. i_chan_resp -> XFER (resp wins if both pulses high);
//          i_chan_nresp -> BACKOFF, req drops next cycle; else stay.
//   BACKOFF: req=0 for exactly BACKOFF cycles, then REQ.
//   XFER : o_chann_req=0; one FIFO word per cycle on o_data/o_data_vld, first
//          word in cycle after resp sampled; o_end=1 with the eop word only;
//          next state IDLE (min 1 idle cycle between o_end and next req).
//  Pulses on resp/nresp outside REQ are ignored (arbiter drives nresp to all
//   non-granted ports). No downstream backpressure: channel accepts every word.
//  o_err: set when full && pkt_cnt==0 (oversized packet); sticky to reset;
//   FSM stays IDLE, buffer stalls.
//  o_data holds last value when o_data_vld=0.
// TESTING
//  1 4-word pkt A0..A3, resp 1 cycle after req -> req 1 from IDLE->REQ, drops
//    on grant; o_data A0..A3 on 4 consecutive cycles, o_end only with A3.
//  2 BACKOFF=4, nresp on first attempt -> req low exactly 4 cycles, high again
//    5th cycle; resp -> packet delivered intact, single o_end.
//  3 two pkts (3 words, 2 words) queued -> two req/resp rounds, req low >=1 cycle
//    after first o_end, words never interleaved, pkt_cnt 2->1->0.
//  4 DEPTH=8, 8-word pkt, no grant -> o_pkt_rdy=0 after 8th write; grant drains,
//    o_pkt_rdy=1 next cycle; 8 words without eop -> o_err=1, stays 1.
//  5 reset asserted during XFER word 2 of 5 -> all outputs 0 at once, o_pkt_rdy
//    =1, no o_end; after release new pkt flows normally.
//  6 write eop and read eop same cycle -> pkt_cnt unchanged; nresp in IDLE and
//    resp+nresp together in REQ -> ignored / treated as grant.

Source files
------------

// File: rtl/chan_req_ctrl.sv
// Per-port channel requester: store-and-forward packet buffer, request/grant
// handshake with refusal backoff, and streaming of the granted packet.
module chan_req_ctrl #(
  parameter int DW      = 16,
  parameter int DEPTH   = 64,
  parameter int BACKOFF = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_pkt_vld,
  input  logic [DW-1:0] i_pkt_data,
  input  logic          i_pkt_eop,
  output logic          o_pkt_rdy,
  output logic          o_chann_req,
  input  logic          i_chan_resp,
  input  logic          i_chan_nresp,
  output logic [DW-1:0] o_data,
  output logic          o_data_vld,
  output logic          o_end,
  output logic          o_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(BACKOFF + 1);

  typedef struct packed {
    logic          eop;
    logic [DW-1:0] data;
  } ent_t;

  typedef enum logic [1:0] {IDLE, REQ, BKOFF, XFER} state_t;

  ent_t          mem [DEPTH];
  ent_t          rd_ent;
  logic [AW:0]   wr_ptr, rd_ptr, pkt_cnt;
  logic          full, wr_en, rd_en;
  state_t        state;
  logic [BW-1:0] bo_cnt;

  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign o_pkt_rdy = ~full;
  assign wr_en     = i_pkt_vld & ~full;
  assign rd_ent    = mem[rd_ptr[AW-1:0]];
  // First word leaves on the grant edge; XFER keeps reading until the eop word is on the bus.
  assign rd_en     = ((state == REQ) && i_chan_resp) || ((state == XFER) && !o_end);

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= {i_pkt_eop, i_pkt_data};
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pkt_cnt <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en & i_pkt_eop, rd_en & rd_ent.eop})
        2'b10:   pkt_cnt <= pkt_cnt + 1'b1;
        2'b01:   pkt_cnt <= pkt_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= IDLE;
      bo_cnt      <= '0;
      o_chann_req <= 1'b0;
      o_data      <= '0;
      o_data_vld  <= 1'b0;
      o_end       <= 1'b0;
      o_err       <= 1'b0;
    end else begin
      o_data_vld <= 1'b0;
      o_end      <= 1'b0;
      // Full buffer with no complete packet can never drain: oversized packet.
      o_err      <= o_err | (full && (pkt_cnt == '0));
      case (state)
        IDLE: begin
          if ((pkt_cnt != '0) && !o_err) begin
            state       <= REQ;
            o_chann_req <= 1'b1;
          end
        end
        REQ: begin
          if (i_chan_resp) begin
            state       <= XFER;
            o_chann_req <= 1'b0;
            o_data      <= rd_ent.data;
            o_data_vld  <= 1'b1;
            o_end       <= rd_ent.eop;
          end else if (i_chan_nresp) begin
            state       <= BKOFF;
            o_chann_req <= 1'b0;
            bo_cnt      <= BW'(BACKOFF - 1);
          end
        end
        BKOFF: begin
          if (bo_cnt == '0) begin
            state       <= REQ;
            o_chann_req <= 1'b1;
          end else begin
            bo_cnt <= bo_cnt - 1'b1;
          end
        end
        XFER: begin
          // The eop word is on the bus now; IDLE next gives the gap before any new request.
          if (o_end) begin
            state <= IDLE;
          end else begin
            o_data     <= rd_ent.data;
            o_data_vld <= 1'b1;
            o_end      <= rd_ent.eop;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_chan_req_ctrl.sv
// Scoreboard bench for chan_req_ctrl: random packets and arbiter behaviour,
// checked cycle by cycle against handshake rules and a word-queue buffer model.
module tb_chan_req_ctrl;
  localparam int DW = 16, DEPTH = 8, BACKOFF = 4;
  localparam int ARB_NONE = 0, ARB_GRANT = 1, ARB_REFUSE = 2, ARB_RAND = 3;

  logic          i_clk = 1'b0, i_rst_n = 1'b0;
  logic          i_pkt_vld = 1'b0, i_pkt_eop = 1'b0;
  logic [DW-1:0] i_pkt_data = '0;
  logic          o_pkt_rdy, o_chann_req, o_data_vld, o_end, o_err;
  logic          i_chan_resp = 1'b0, i_chan_nresp = 1'b0;
  logic [DW-1:0] o_data;

  typedef struct packed {
    logic          eop;
    logic [DW-1:0] d;
  } word_t;

  word_t exp_q[$];
  int total = 0, bad = 0, n_end = 0;
  int arb_mode = ARB_NONE, refuse_left = 0;

  chan_req_ctrl #(.DW(DW), .DEPTH(DEPTH), .BACKOFF(BACKOFF)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_pkt_vld(i_pkt_vld), .i_pkt_data(i_pkt_data), .i_pkt_eop(i_pkt_eop),
    .o_pkt_rdy(o_pkt_rdy), .o_chann_req(o_chann_req),
    .i_chan_resp(i_chan_resp), .i_chan_nresp(i_chan_nresp),
    .o_data(o_data), .o_data_vld(o_data_vld), .o_end(o_end), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s: got timeout want event at %0t", nm, $time);
  endtask

  function automatic bit has_eop();
    foreach (exp_q[i]) if (exp_q[i].eop) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk_reset(input string p);
    chk({p, "_req"}, o_chann_req, 0);
    chk({p, "_vld"}, o_data_vld, 0);
    chk({p, "_end"}, o_end, 0);
    chk({p, "_err"}, o_err, 0);
    chk({p, "_data"}, o_data, 0);
    chk({p, "_rdy"}, o_pkt_rdy, 1);
  endtask

  // Arbiter: sees req in one cycle, answers with a pulse in the next.
  initial begin : arb
    bit r;
    int k;
    forever begin
      @(negedge i_clk);
      r = o_chann_req;
      @(posedge i_clk);
      #1;
      i_chan_resp  = 1'b0;
      i_chan_nresp = 1'b0;
      case (arb_mode)
        ARB_GRANT: i_chan_resp = r;
        ARB_REFUSE: if (r) begin
          if (refuse_left > 0) begin i_chan_nresp = 1'b1; refuse_left--; end
          else i_chan_resp = 1'b1;
        end
        ARB_RAND: begin
          k = $urandom_range(0, 3);
          if (r) begin
            i_chan_nresp = (k == 1 || k == 3);
            i_chan_resp  = (k == 2 || k == 3);
          end else if ($urandom_range(0, 7) == 0) begin
            i_chan_nresp = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Monitor: pops expected words and checks the request/backoff/stream rules.
  initial begin : mon
    logic  p_req, p_resp, p_nresp, p_vld, p_end;
    int    bo_left;
    bit    err_flag;
    word_t w;
    p_req = 0; p_resp = 0; p_nresp = 0; p_vld = 0; p_end = 0;
    bo_left = -1; err_flag = 0;
    forever begin
      @(negedge i_clk);
      if (!i_rst_n) begin
        p_req = 0; p_resp = 0; p_nresp = 0; p_vld = 0; p_end = 0;
        bo_left = -1; err_flag = 0;
        continue;
      end
      chk("vld_seq", o_data_vld, (p_req & p_resp) | (p_vld & ~p_end));
      if (o_data_vld) begin
        if (exp_q.size() == 0) fail_now("underflow");
        else begin
          w = exp_q.pop_front();
          chk("data", o_data, w.d);
          chk("end", o_end, w.eop);
        end
        if (o_end) n_end++;
      end else begin
        chk("end_novld", o_end, 0);
      end
      if (p_req && p_resp) chk("req_grant", o_chann_req, 0);
      else if (p_req && p_nresp) begin
        chk("req_nresp", o_chann_req, 0);
        bo_left = BACKOFF - 1;
      end
      else if (p_req) chk("req_hold", o_chann_req, 1);
      else if (bo_left > 0) begin
        chk("bo_low", o_chann_req, 0);
        bo_left--;
      end
      else if (bo_left == 0) begin
        chk("bo_rereq", o_chann_req, 1);
        bo_left = -1;
      end
      else if (o_chann_req) chk("req_has_pkt", has_eop(), 1);
      if (p_vld && p_end) chk("gap_after_end", o_chann_req, 0);
      chk("rdy", o_pkt_rdy, exp_q.size() < DEPTH);
      chk("err", o_err, err_flag);
      if (exp_q.size() == DEPTH && !has_eop()) err_flag = 1;
      p_req = o_chann_req; p_resp = i_chan_resp; p_nresp = i_chan_nresp;
      p_vld = o_data_vld; p_end = o_end;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the last accepted write.
  task automatic send_pkt(input int len, input bit with_eop, input int gap);
    for (int i = 0; i < len; i++) begin
      word_t w;
      int    tries;
      repeat ($urandom_range(0, gap)) begin @(posedge i_clk); #1; end
      w.d   = DW'($urandom);
      w.eop = with_eop && (i == len - 1);
      i_pkt_vld = 1'b1; i_pkt_data = w.d; i_pkt_eop = w.eop;
      tries = 0;
      forever begin
        @(negedge i_clk);
        #1;
        if (o_pkt_rdy) begin
          exp_q.push_back(w);
          @(posedge i_clk); #1;
          break;
        end
        @(posedge i_clk); #1;
        if (++tries > 500) begin fail_now("wr_stall"); break; end
      end
      i_pkt_vld = 1'b0; i_pkt_eop = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int c = 0;
    do begin
      @(negedge i_clk); #1;
      c++;
    end while ((exp_q.size() != 0 || o_chann_req || o_data_vld) && c < budget);
    if (c >= budget) fail_now("drain");
    @(posedge i_clk); #1;
  endtask

  initial begin : main
    int cnt, base;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk_reset("rst");
    #2 i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Single 4-word packet, immediate grant
    arb_mode = ARB_GRANT;
    send_pkt(4, 1, 0);
    wait_drain(200);
    chk("t1_ends", n_end, 1);

    // One refusal then grant
    arb_mode = ARB_REFUSE; refuse_left = 1;
    send_pkt(5, 1, 0);
    wait_drain(200);
    chk("t2_ends", n_end, 2);
    chk("t2_refused", refuse_left, 0);

    // Two packets queued before any grant
    arb_mode = ARB_NONE;
    send_pkt(3, 1, 0);
    send_pkt(2, 1, 0);
    repeat (4) @(posedge i_clk);
    #1 arb_mode = ARB_GRANT;
    wait_drain(200);
    chk("t3_ends", n_end, 4);

    // Max-length packet fills the buffer, then drains
    arb_mode = ARB_NONE;
    send_pkt(DEPTH, 1, 0);
    @(negedge i_clk); #1;
    chk("t4_full", o_pkt_rdy, 0);
    arb_mode = ARB_GRANT;
    wait_drain(200);
    chk("t4_ends", n_end, 5);

    // Random traffic and arbiter behaviour
    arb_mode = ARB_RAND;
    base = n_end;
    for (int p = 0; p < 60; p++) send_pkt($urandom_range(1, DEPTH), 1, 3);
    wait_drain(4000);
    chk("rand_ends", n_end, base + 60);

    // Reset during the second word of a 5-word transfer
    arb_mode = ARB_GRANT;
    send_pkt(5, 1, 0);
    cnt = 0;
    for (int c = 0; c < 200 && cnt < 2; c++) begin
      @(negedge i_clk);
      if (o_data_vld) cnt++;
    end
    if (cnt < 2) fail_now("t5_xfer");
    base = n_end;
    #2 i_rst_n = 1'b0;
    #1 chk_reset("t5_rst");
    exp_q.delete();
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    send_pkt(3, 1, 0);
    wait_drain(200);
    chk("t5_ends", n_end, base + 1);

    // Oversized packet: buffer fills without eop
    arb_mode = ARB_RAND;
    send_pkt(DEPTH, 0, 0);
    repeat (3) @(negedge i_clk);
    #1 chk("t6_err", o_err, 1);
    chk("t6_rdy", o_pkt_rdy, 0);
    repeat (10) @(negedge i_clk);
    #1 chk("t6_err_sticky", o_err, 1);
    chk("t6_noreq", o_chann_req, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #500000;
    bad++;
    $display("FAIL watchdog: got timeout want finish");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end
endmodule
